// File: rtl/tt_um_uart_tx_buffered.sv
// 8N1 UART transmitter with a one-entry holding register for gap-free frames.
// uo_out = {frame_count[3:0], ready, done, busy, tx}; all uio pins are inputs.
module tt_um_uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [7:0]       hold_data, hold_data_d;
  logic             hold_full, hold_full_d;
  logic [7:0]       shift, shift_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [CYC_W-1:0] cyc, cyc_d;
  logic [3:0]       frame_count, frame_count_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             last_cyc;
  logic             unused_ok;

  // Only bit 0 of uio_in carries information.
  assign unused_ok = &{1'b0, uio_in[7:1]};

  assign uo_out  = {frame_count, ready_q, done_q, busy_q, tx_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d       = state;
    hold_data_d   = hold_data;
    hold_full_d   = hold_full;
    shift_d       = shift;
    bit_idx_d     = bit_idx;
    cyc_d         = cyc;
    frame_count_d = frame_count;
    tx_d          = 1'b1;
    done_d        = 1'b0;
    accept        = ena & uio_in[0] & ~hold_full;
    last_cyc      = (cyc == CYC_LAST);

    case (state)
      IDLE: begin
        if (hold_full) begin
          shift_d     = hold_data;
          hold_full_d = 1'b0;
          cyc_d       = '0;
          state_d     = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (last_cyc) begin
          cyc_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          cyc_d = cyc + CYC_W'(1);
        end
      end
      DATA: begin
        tx_d = shift[bit_idx];
        if (last_cyc) begin
          cyc_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          cyc_d = cyc + CYC_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (last_cyc) begin
          done_d        = 1'b1;
          frame_count_d = frame_count + 4'd1;
          cyc_d         = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (hold_full) begin
            shift_d     = hold_data;
            hold_full_d = 1'b0;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc + CYC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance only happens with the hold empty, so it never meets a transfer.
    if (accept) begin
      hold_data_d = ui_in;
      hold_full_d = 1'b1;
    end

    busy_d  = (state != IDLE);
    ready_d = ~hold_full_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data   <= 8'h00;
      hold_full   <= 1'b0;
      shift       <= 8'h00;
      bit_idx     <= 3'd0;
      cyc         <= '0;
      frame_count <= 4'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      hold_data   <= hold_data_d;
      hold_full   <= hold_full_d;
      shift       <= shift_d;
      bit_idx     <= bit_idx_d;
      cyc         <= cyc_d;
      frame_count <= frame_count_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: tb/tb_tt_um_uart_tx_buffered.sv
// Scoreboard bench: driver predicts each accepted byte and its start-bit cycle,
// monitor checks every line sample against the predicted frame.
module tb_tt_um_uart_tx_buffered;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         start;
  } item_t;

  item_t      q[$];
  int         edge_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         last_start = -1000;
  int         model_fc = 0;
  int         done_cnt = 0;
  bit         in_frame = 0;
  int         fstart = 0;
  logic [9:0] frame_bits = '0;
  int         pos, bidx, exp_tx, exp_done, exp_busy;

  tt_um_uart_tx_buffered #(.CLKS_PER_BIT(C)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  // Hold register is occupied from its accept edge until the edge before its start bit.
  function automatic bit model_ready(input int k);
    foreach (q[i]) begin
      if (q[i].acc <= k && k <= q[i].start - 2) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor: compare the line and status outputs against the expected frames.
  always @(negedge clk) begin
    check("uio_out", int'(uio_out), 0);
    check("uio_oe", int'(uio_oe), 0);
    if (!rst_n) begin
      q.delete();
      in_frame = 0;
      model_fc = 0;
      check("reset_uo_out", int'(uo_out), 9);
    end else begin
      if (!in_frame && q.size() > 0 && q[0].start == edge_cnt) begin
        frame_bits = {1'b1, q[0].data, 1'b0};
        fstart     = edge_cnt;
        in_frame   = 1;
        void'(q.pop_front());
      end
      if (in_frame) begin
        pos      = edge_cnt - fstart;
        bidx     = pos / C;
        exp_tx   = int'((frame_bits >> bidx) & 10'd1);
        exp_done = (pos == FRAME - 1) ? 1 : 0;
        exp_busy = 1;
      end else begin
        exp_tx   = 1;
        exp_done = 0;
        exp_busy = 0;
      end
      if (exp_done == 1) model_fc = (model_fc + 1) % 16;
      check("tx", int'(uo_out[0]), exp_tx);
      check("busy", int'(uo_out[1]), exp_busy);
      check("done", int'(uo_out[2]), exp_done);
      check("ready", int'(uo_out[3]), int'(model_ready(edge_cnt)));
      check("frame_count", int'(uo_out[7:4]), model_fc);
      if (uo_out[2]) done_cnt++;
      if (exp_done == 1) in_frame = 0;
    end
  end

  // One driver cycle: called at negedge+1, returns at the next negedge+1.
  task automatic drive(input bit e, input bit v, input logic [7:0] d, output bit accepted);
    item_t it;
    ena      = e;
    uio_in   = {7'($urandom), v};
    ui_in    = d;
    accepted = 1'b0;
    if (e && v && rst_n && model_ready(edge_cnt)) begin
      it.data  = d;
      it.acc   = edge_cnt + 1;
      it.start = (it.acc + 2 > last_start + FRAME) ? it.acc + 2 : last_start + FRAME;
      last_start = it.start;
      q.push_back(it);
      accepted = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset_uo_out", int'(uo_out), 9);
    check("async_reset_tx", int'(uo_out[0]), 1);
    last_start = -1000;
    repeat (2) @(negedge clk);
    #1;
    uio_in = 8'h00;
    rst_n  = 1'b1;
    done_cnt = 0;
  endtask

  task automatic wait_idle();
    bit acc;
    int n;
    n = 0;
    while ((q.size() > 0 || in_frame) && n < 2000) begin
      drive(1'b1, 1'b0, 8'($urandom), acc);
      n++;
    end
    check("idle_timeout", (n < 2000) ? 1 : 0, 1);
  endtask

  initial begin
    bit acc;
    int s, pushed, n;
    rst_n  = 1'b1;
    ena    = 1'b1;
    uio_in = 8'h01;
    ui_in  = 8'($urandom);
    #1;
    // Test 1: reset with valid high and a random byte offered.
    do_reset();
    check("post_reset_uo_out", int'(uo_out), 9);

    // Test 2: single 0xA5 frame.
    drive(1'b1, 1'b1, 8'hA5, acc);
    check("a5_accepted", int'(acc), 1);
    wait_idle();
    repeat (3) drive(1'b1, 1'b0, 8'h00, acc);
    check("a5_done_count", done_cnt, 1);
    check("a5_frame_count", int'(uo_out[7:4]), 1);
    check("a5_busy_after", int'(uo_out[1]), 0);

    // Test 3: 0x00 then 0xFF offered mid-frame; must chain with no gap.
    do_reset();
    drive(1'b1, 1'b1, 8'h00, acc);
    repeat (10) drive(1'b1, 1'b0, 8'h00, acc);
    drive(1'b1, 1'b1, 8'hFF, acc);
    check("ff_accepted", int'(acc), 1);
    check("ready_low_after_second", int'(uo_out[3]), 0);
    wait_idle();
    check("b2b_frame_count", int'(uo_out[7:4]), 2);
    check("b2b_done_count", done_cnt, 2);
    check("b2b_ready", int'(uo_out[3]), 1);

    // Test 4: ena low blocks acceptance.
    do_reset();
    repeat (100) drive(1'b0, 1'b1, 8'h3C, acc);
    check("gated_frame_count", int'(uo_out[7:4]), 0);
    check("gated_tx", int'(uo_out[0]), 1);
    check("gated_ready", int'(uo_out[3]), 1);

    // Test 5: reset during data bit 3, then a fresh byte.
    do_reset();
    drive(1'b1, 1'b1, 8'($urandom), acc);
    s = last_start;
    n = 0;
    while (edge_cnt < s + 4 * C + 1 && n < 200) begin
      drive(1'b1, 1'b0, 8'h00, acc);
      n++;
    end
    check("reached_bit3", (edge_cnt == s + 4 * C + 1) ? 1 : 0, 1);
    #2;
    do_reset();
    drive(1'b1, 1'b1, 8'($urandom), acc);
    wait_idle();
    check("after_abort_frame_count", int'(uo_out[7:4]), 1);

    // Test 6: valid held high for 16 frames; counter wraps to 0.
    do_reset();
    pushed = 0;
    n = 0;
    while (pushed < 16 && n < 2000) begin
      drive(1'b1, 1'b1, 8'($urandom), acc);
      if (acc) pushed++;
      n++;
    end
    check("wrap_pushed", pushed, 16);
    wait_idle();
    repeat (2) drive(1'b1, 1'b0, 8'h00, acc);
    check("wrap_done_count", done_cnt, 16);
    check("wrap_frame_count", int'(uo_out[7:4]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tt_um_uart_tx_buffered.md
Name: tt_um_uart_tx_buffered

Overview:
Tiny Tapeout user project that serialises bytes offered by the external driver into an 8N1 UART stream on a dedicated output pin. It is the transmitting end the team's UART receiver designs are tested against. It uses the standard TT user-project port set. A one-entry holding register lets the driver queue the next byte while the current frame shifts out, giving gap-free back-to-back frames.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal values >= 2; bit counter width is clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock; the only clock.
rst_n  input  1  asynchronous, active-low reset.
ena  input  1  design selected; byte acceptance is gated by it.
ui_in  input  8  byte to transmit; sampled on acceptance.
uio_in  input  8  bit0 = valid; bits 7:1 are ignored.
uo_out  output  8  [0] tx, [1] busy, [2] done, [3] ready, [7:4] frame_count.
uio_out  output  8  constant 0.
uio_oe  output  8  constant 0; all uio pins are inputs.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - tx=1, busy=0, done=0, ready=1, frame_count=0.
  - Holding register is emptied; FSM goes to IDLE; bit and cycle counters are 0.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately.
- Accept:
  - On a rising edge where ena=1, valid=1 and ready=1, ui_in is latched into the holding register and hold_full is set.
  - ready = !hold_full, driven from a register.
  - valid is level-sensitive: holding it high accepts one byte per cycle in which ready=1.
- ena=0:
  - No new bytes are accepted.
  - A frame in progress and a byte already held still complete.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if hold_full, move the held byte to the shift register, clear hold_full, go to START.
  - Latency: a byte accepted at edge N puts tx=0 after edge N+2. Edge N+1 does the IDLE to START transfer; the tx=0 register updates on the following edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles; a bit index of 0..7 selects the bit; then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle: done pulses high for exactly 1 cycle and frame_count increments, wrapping 15 to 0.
  - After STOP, if hold_full, load the held byte and go directly to START with no idle cycle; otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- busy = (state != IDLE). tx is 1 whenever in IDLE.
- Simultaneous events:
  - An accept on the same edge as the STOP to IDLE transition is held normally; IDLE then launches it on the next edge.
  - Hold transfer and accept can never coincide, because ready is 0 while hold_full.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, CLKS_PER_BIT=4: assert rst_n=0 with valid=1 and random ui_in -> uo_out=8'h09, uio_out=0, uio_oe=0.
2. Single byte 8'hA5, ena=1, valid for 1 cycle:
   - tx bits, each 4 cycles: 0,1,0,1,0,0,1,0,1,1.
   - tx goes low 2 edges after acceptance.
   - done pulses once 40 cycles after the start bit begins.
   - frame_count=1; busy low afterwards.
3. Back-to-back: send 8'h00, then offer 8'hFF mid-frame:
   - ready drops after the second accept.
   - The second start bit follows the first stop bit with zero idle cycles.
   - frame_count=2; ready=1 once the second byte leaves the hold.
4. Gating: ena=0, valid=1, ui_in=8'h3C for 100 cycles -> tx stays 1, ready stays 1, frame_count=0.
5. Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 and uo_out=8'h09 without a clock edge. A subsequent new byte transmits correctly.
6. Wrap: send 16 frames with valid held high -> 16 done pulses, frame_count returns to 0, no frames dropped or duplicated.
